// File: rtl/irq_wdog_pkg.sv
// Shared types and constants for the interrupt/watchdog controller.
//   rst_state_e      : reset-stretch FSM states (HOLD, RUN)
//   *_ADDR_DEF       : default bus addresses for ack, status read and kick
//   STAT_*           : bit positions inside the status byte
package irq_wdog_pkg;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } rst_state_e;

  localparam logic [15:0] IRQ_ACK_ADDR_DEF = 16'h1800;
  localparam logic [15:0] STATUS_ADDR_DEF  = 16'h1801;
  localparam logic [15:0] WDOG_ADDR_DEF    = 16'h1C00;

  localparam int STAT_PENDING_BIT = 7;
  localparam int STAT_STICKY_BIT  = 6;
  localparam int STAT_MISSED_MSB  = 2;
  localparam int STAT_MISSED_LSB  = 0;

  localparam logic [2:0] MISSED_MAX = 3'd7;

endpackage

// File: rtl/wdog_timer.sv
// Watchdog timer: up-counter that restarts on every kick and raises a
// single-cycle fire pulse once TIMEOUT cycles pass without a kick.
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   hold_i  : CPU is held in reset; counter parked at 0, no fire
//   kick_i  : reload strobe from the bus decode
//   fire_o  : combinational fire pulse in the terminal cycle
module wdog_timer #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic hold_i,
  input  logic kick_i,
  output logic fire_o
);

  localparam logic [15:0] TERM = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;

  // A kick in the terminal cycle wins over the fire.
  assign fire_o = ~hold_i & ~kick_i & (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (hold_i || kick_i || fire_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/irq_watchdog_ctrl.sv
// Periodic interrupt and watchdog controller in front of the 6502 wrapper.
// Raises irq_n every IRQ_PERIOD cycles until acknowledged by a bus write,
// counts missed ticks, stretches the CPU reset after rst or a watchdog
// fire, and offers a status byte for the CPU read mux.
//   clk, rst     : system clock, asynchronous active-low reset
//   AB, WE, DO   : snooped CPU bus (DO value is never decoded)
//   irq_n        : registered active-low interrupt request
//   cpu_rst_n    : active-low CPU reset
//   rd_hit       : status address being read this cycle
//   rd_data      : {pending, wdog_fired_sticky, 3'b0, missed[2:0]}
// Optional watchdog: define IRQ_WATCHDOG_EN to build the wdog_timer,
// the kick decode and the sticky fired flag.
//
// Reset-stretch FSM:
//   state | meaning
//   HOLD  | cpu_rst_n low, pulse counter runs RST_PULSE cycles
//   RUN   | cpu_rst_n high, interrupts and watchdog active
module irq_watchdog_ctrl
  import irq_wdog_pkg::*;
#(
  parameter int          IRQ_PERIOD   = 6048,
  parameter logic [15:0] IRQ_ACK_ADDR = IRQ_ACK_ADDR_DEF,
  parameter logic [15:0] STATUS_ADDR  = STATUS_ADDR_DEF,
  parameter logic [15:0] WDOG_ADDR    = WDOG_ADDR_DEF,
  parameter int          WDOG_TIMEOUT = 65535,
  parameter int          RST_PULSE    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] AB,
  input  logic        WE,
  input  logic [7:0]  DO,
  output logic        irq_n,
  output logic        cpu_rst_n,
  output logic        rd_hit,
  output logic [7:0]  rd_data
);

  localparam logic [15:0] PER_TERM   = 16'(IRQ_PERIOD - 1);
  localparam logic [15:0] PULSE_TERM = 16'(RST_PULSE - 1);

  rst_state_e  state_q, state_d;
  logic [15:0] pulse_q, pulse_d;
  logic [15:0] per_q, per_d;
  logic        pend_q, pend_d;
  logic [2:0]  missed_q, missed_d;
  logic        sticky;
  logic        run, ack, tick, wdog_fire;

  assign run  = (state_q == RUN);
  assign ack  = run & WE & (AB == IRQ_ACK_ADDR);
  assign tick = run & (per_q == PER_TERM);

`ifdef IRQ_WATCHDOG_EN
  logic kick;
  logic sticky_q;
  logic unused_do;

  assign kick      = run & WE & (AB == WDOG_ADDR);
  assign unused_do = ^DO;

  wdog_timer #(
    .TIMEOUT (WDOG_TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .hold_i (~run),
    .kick_i (kick),
    .fire_o (wdog_fire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           sticky_q <= 1'b0;
    else if (wdog_fire) sticky_q <= 1'b1;
  end

  assign sticky = sticky_q;
`else
  logic unused_cfg;

  assign unused_cfg = ^{DO, WDOG_ADDR, 16'(WDOG_TIMEOUT)};
  assign wdog_fire  = 1'b0;
  assign sticky     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pulse_d = pulse_q;
    case (state_q)
      HOLD: begin
        if (pulse_q == PULSE_TERM) begin
          state_d = RUN;
          pulse_d = '0;
        end else begin
          pulse_d = pulse_q + 16'd1;
        end
      end
      RUN: begin
        if (wdog_fire) begin
          state_d = HOLD;
          pulse_d = '0;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  // Interrupt datapath. Leaving RUN (or firing) wipes everything so that
  // irq_n stays high for the whole reset stretch.
  always_comb begin
    per_d    = per_q + 16'd1;
    pend_d   = tick | (pend_q & ~ack);
    missed_d = missed_q;
    if (ack) begin
      missed_d = '0;
    end else if (tick && pend_q && (missed_q != MISSED_MAX)) begin
      missed_d = missed_q + 3'd1;
    end
    if (tick) per_d = '0;
    if (!run || wdog_fire) begin
      per_d    = '0;
      pend_d   = 1'b0;
      missed_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= HOLD;
      pulse_q  <= '0;
      per_q    <= '0;
      pend_q   <= 1'b0;
      missed_q <= '0;
    end else begin
      state_q  <= state_d;
      pulse_q  <= pulse_d;
      per_q    <= per_d;
      pend_q   <= pend_d;
      missed_q <= missed_d;
    end
  end

  assign irq_n     = ~pend_q;
  assign cpu_rst_n = run;
  assign rd_hit    = ~WE & (AB == STATUS_ADDR);

  always_comb begin
    rd_data                                  = '0;
    rd_data[STAT_PENDING_BIT]                = pend_q;
    rd_data[STAT_STICKY_BIT]                 = sticky;
    rd_data[STAT_MISSED_MSB:STAT_MISSED_LSB] = missed_q;
  end

endmodule

// File: tb/tb_irq_watchdog_ctrl.sv
module tb_irq_watchdog_ctrl;

  localparam int PER   = 16;
  localparam int TMO   = 64;
  localparam int RST_P = 4;
  localparam logic [15:0] A_ACK  = 16'h1800;
  localparam logic [15:0] A_STAT = 16'h1801;
  localparam logic [15:0] A_WDOG = 16'h1C00;
`ifdef IRQ_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] AB = 16'h0000;
  logic        WE = 1'b0;
  logic [7:0]  DO = 8'h00;
  logic        irq_n, cpu_rst_n, rd_hit;
  logic [7:0]  rd_data;

  int n_cmp  = 0;
  int n_fail = 0;

  irq_watchdog_ctrl #(
    .IRQ_PERIOD   (PER),
    .WDOG_TIMEOUT (TMO),
    .RST_PULSE    (RST_P)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .AB        (AB),
    .WE        (WE),
    .DO        (DO),
    .irq_n     (irq_n),
    .cpu_rst_n (cpu_rst_n),
    .rd_hit    (rd_hit),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural reference: cycles since release, phase within the period,
  // idle cycles since the last kick, and the interrupt bookkeeping.
  bit m_run, m_pend, m_sticky, m_ack, m_kick, m_tick;
  int m_hold_left, m_phase, m_missed, m_idle;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0; m_hold_left = RST_P; m_phase = 0; m_pend = 0;
      m_missed = 0; m_idle = 0; m_sticky = 0;
    end else if (!m_run) begin
      m_hold_left = m_hold_left - 1;
      if (m_hold_left == 0) m_run = 1;
    end else begin
      m_ack  = WE && (AB == A_ACK);
      m_kick = WD_EN && WE && (AB == A_WDOG);
      m_tick = (m_phase == PER - 1);
      if (WD_EN && !m_kick && m_idle == TMO - 1) begin
        m_run = 0; m_hold_left = RST_P; m_sticky = 1;
        m_pend = 0; m_missed = 0; m_phase = 0; m_idle = 0;
      end else begin
        if (m_ack) m_missed = 0;
        else if (m_tick && m_pend && m_missed < 7) m_missed = m_missed + 1;
        m_pend  = m_tick || (m_pend && !m_ack);
        m_phase = (m_phase + 1) % PER;
        m_idle  = m_kick ? 0 : m_idle + 1;
      end
    end
  end

  function automatic logic [7:0] m_status();
    return {m_pend, m_sticky, 3'b000, 3'(m_missed)};
  endfunction

  task automatic step(input logic we, input logic [15:0] ab);
    WE = we;
    AB = ab;
    DO = 8'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input bit keepalive);
    if (keepalive && m_run && m_idle >= 40) step(1'b1, A_WDOG);
    else step(1'b0, 16'h0000);
  endtask

  task automatic test_reset();
    step(1'b0, A_STAT);
    n_cmp++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL reset_irq_n: got %b expected 1", irq_n); end
    n_cmp++; if (cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_rst_n: got %b expected 0", cpu_rst_n); end
    n_cmp++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
    n_cmp++; if (rd_hit !== 1'b1) begin n_fail++; $display("FAIL reset_rd_hit: got %b expected 1", rd_hit); end
    step(1'b0, 16'h0000);
  endtask

  task automatic test_powerup();
    int e;
    rst = 1'b1;
    e = 0;
    do begin nop(1); e++; end while (cpu_rst_n !== 1'b1 && e < 50);
    n_cmp++; if (e != RST_P) begin n_fail++; $display("FAIL powerup_release_edges: got %0d expected %0d", e, RST_P); end
    e = 0;
    do begin nop(1); e++; end while (irq_n !== 1'b0 && e < 100);
    n_cmp++; if (e != PER) begin n_fail++; $display("FAIL powerup_first_irq: got %0d expected %0d", e, PER); end
    n_cmp++; if (rd_data !== 8'h80) begin n_fail++; $display("FAIL powerup_rd_data: got %h expected 80", rd_data); end
  endtask

  task automatic test_ack();
    int e;
    step(1'b1, A_ACK);
    n_cmp++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL ack_irq_n: got %b expected 1", irq_n); end
    n_cmp++; if (rd_data[2:0] !== 3'd0) begin n_fail++; $display("FAIL ack_missed: got %0d expected 0", rd_data[2:0]); end
    e = 0;
    do begin nop(1); e++; end while (irq_n !== 1'b0 && e < 100);
    n_cmp++; if (e != PER - 1) begin n_fail++; $display("FAIL ack_next_irq: got %0d expected %0d", e, PER - 1); end
  endtask

  task automatic test_missed();
    int bad;
    bad = 0;
    for (int i = 0; i < 10 * PER; i++) begin
      nop(1);
      if (irq_n !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL missed_irq_held: got %0d high cycles expected 0", bad); end
    n_cmp++; if (rd_data !== 8'h87) begin n_fail++; $display("FAIL missed_rd_data: got %h expected 87", rd_data); end
  endtask

  task automatic test_collision();
    int e;
    step(1'b1, A_ACK);
    n_cmp++; if (rd_data !== m_status()) begin n_fail++; $display("FAIL coll_pre_ack: got %h expected %h", rd_data, m_status()); end
    e = 0;
    while (m_phase != PER - 1 && e < 40) begin nop(1); e++; end
    step(1'b1, A_ACK);
    n_cmp++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL coll_pending: irq_n got %b expected 0", irq_n); end
    n_cmp++; if (rd_data !== 8'h80) begin n_fail++; $display("FAIL coll_rd_data: got %h expected 80", rd_data); end
  endtask

  task automatic test_watchdog();
    int e, bad;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, A_WDOG);
      if (cpu_rst_n !== 1'b1) bad++;
      for (int i = 0; i < 49; i++) begin
        nop(0);
        if (cpu_rst_n !== 1'b1) bad++;
      end
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL wdog_kicked_no_fire: got %0d reset cycles expected 0", bad); end
    step(1'b1, A_WDOG);
    e = 0;
    do begin nop(0); e++; end while (cpu_rst_n !== 1'b0 && e < 100);
`ifdef IRQ_WATCHDOG_EN
    n_cmp++; if (e != TMO) begin n_fail++; $display("FAIL wdog_fire_edges: got %0d expected %0d", e, TMO); end
    bad = 0;
    n_cmp++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL wdog_hold_irq_entry: got %b expected 1", irq_n); end
    e = 0;
    do begin nop(0); e++; if (cpu_rst_n !== 1'b1 && irq_n !== 1'b1) bad++; end
      while (cpu_rst_n !== 1'b1 && e < 20);
    n_cmp++; if (e != RST_P) begin n_fail++; $display("FAIL wdog_hold_len: got %0d expected %0d", e, RST_P); end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL wdog_hold_irq: got %0d low cycles expected 0", bad); end
    n_cmp++; if (rd_data !== 8'h40) begin n_fail++; $display("FAIL wdog_sticky: got %h expected 40", rd_data); end
`else
    n_cmp++; if (e != 100) begin n_fail++; $display("FAIL wdog_absent: reset after %0d edges expected none", e); end
    n_cmp++; if (rd_data[6] !== 1'b0) begin n_fail++; $display("FAIL wdog_sticky_absent: got %b expected 0", rd_data[6]); end
`endif
  endtask

  task automatic test_reset_async();
    int e;
    e = 0;
    while (irq_n !== 1'b0 && e < 40) begin nop(1); e++; end
    n_cmp++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL async_pre_irq: got %b expected 0", irq_n); end
    #3 rst = 1'b0;
    #1;
    n_cmp++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL async_irq_n: got %b expected 1", irq_n); end
    n_cmp++; if (cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL async_cpu_rst_n: got %b expected 0", cpu_rst_n); end
    n_cmp++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL async_rd_data: got %h expected 00", rd_data); end
    step(1'b0, 16'h0000);
    step(1'b0, 16'h0000);
  endtask

  task automatic test_random();
    int r, bad_irq, bad_rst, bad_rd, bad_hit;
    bit kicks_on;
    bad_irq = 0; bad_rst = 0; bad_rd = 0; bad_hit = 0;
    rst = 1'b1;
    for (int c = 0; c < 800; c++) begin
      kicks_on = !(c >= 200 && c < 320);
      r = int'($urandom_range(0, 99));
      if (r < 8)                   step(1'b1, A_ACK);
      else if (r < 16 && kicks_on) step(1'b1, A_WDOG);
      else if (r < 26)             step(1'b0, A_STAT);
      else if (r < 30)             step(1'b1, A_STAT);
      else begin
        AB = 16'($urandom);
        if (AB == A_WDOG) AB = 16'h0000;
        step(1'($urandom), AB);
      end
      if (irq_n !== !m_pend) bad_irq++;
      if (cpu_rst_n !== m_run) bad_rst++;
      if (rd_data !== m_status()) bad_rd++;
      if (rd_hit !== (!WE && AB == A_STAT)) bad_hit++;
      if (c == 500) begin
        #3 rst = 1'b0;
        #1 if (irq_n !== 1'b1 || cpu_rst_n !== 1'b0) bad_rst++;
        step(1'b0, 16'h0000);
        rst = 1'b1;
      end
    end
    n_cmp++; if (bad_irq != 0) begin n_fail++; $display("FAIL rand_irq_n: %0d cycles differ, expected 0", bad_irq); end
    n_cmp++; if (bad_rst != 0) begin n_fail++; $display("FAIL rand_cpu_rst_n: %0d cycles differ, expected 0", bad_rst); end
    n_cmp++; if (bad_rd != 0) begin n_fail++; $display("FAIL rand_rd_data: %0d cycles differ, expected 0", bad_rd); end
    n_cmp++; if (bad_hit != 0) begin n_fail++; $display("FAIL rand_rd_hit: %0d cycles differ, expected 0", bad_hit); end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_ack();
    test_missed();
    test_collision();
    test_watchdog();
    test_reset_async();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
